mmio_hex_scan: RTL
==================

Name: mmio_hex_scan

Overview:
Memory-mapped multi-digit seven-segment display controller on the shared ABUS/DBUS processor bus.
- Holds a DIGITS-nibble value register, a control register and a read-only status register.
- Time-multiplexes the digits onto one shared segment bus with active-low anode selects.
- Supports per-digit blanking and per-digit blinking.
- Replaces the single-register hex latch as the board's display peripheral.

Parameters:
BITS, 32, bus address/data width.
BASE, 32'hFFFFF000, byte address of register 0; window is BASE..BASE+15.
DIGITS, 6, number of digits (1..8); DATA width is 4*DIGITS.
SCAN_DIV, 50000, clocks per digit slot (>=2).
BLINK_FRAMES, 64, full scan frames per blink-phase toggle (>=1).

Ports:
CLK  in  1  system clock.
RST  in  1  reset.
ABUS  in  BITS  byte address.
DBUS  inout  BITS  data bus; high-Z unless this block is read.
WE  in  1  write enable; 1 = write cycle, 0 = read.
SEG  out  7  segments gfedcba, active-low.
AN  out  DIGITS  digit selects, active-low, one-hot-low while scanning.

Interface (already decided): one clock; reset is synchronous and active-high. Clock is CLK, reset is RST.

Behaviour:
Decode and register map:
- sel = ABUS in [BASE, BASE+16); register index = ABUS[3:2].
- 0 DATA (RW): bits [4*DIGITS-1:0] = value; digit 0 is the low nibble.
- 1 CTRL (RW): bit0 EN; bit1 SYNC (write-only pulse, reads 0); bits [8+DIGITS-1:8] BLANK mask; bits [16+DIGITS-1:16] BLINK mask.
- 2 STATUS (RO): bits[2:0] current digit index; bit8 blink phase; bit9 EN.
- 3: reserved; reads 0, writes ignored.
- Writes to STATUS are ignored. Unused register bits read 0 and are not stored.

Bus timing:
- Write: latched on the CLK edge where sel && WE.
- Read: DBUS is driven combinationally while sel && !WE, with zero-extended register contents; otherwise high-Z.

Reset (RST high at an edge):
- DATA=0; CTRL=0x1 (EN=1, no blank, no blink).
- Prescaler=0, index=0, frame count=0, blink phase=0.
- SEG=7'h7F, AN all ones.
- RST mid-scan or mid-write wins over everything; a write in the same cycle is dropped.

Scan timing:
- Prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the index advances; index DIGITS-1 wraps to 0.
- On index wrap the frame count increments. When the frame count reaches BLINK_FRAMES-1 it clears and the blink phase toggles.

Outputs (registered, one cycle after the index/data they reflect):
- For the current index i, AN[i]=0 and all others 1; SEG = decode(DATA nibble i).
- Digit i is dark (AN all ones, SEG=7'h7F) if BLANK[i], or if BLINK[i] && phase==1.
- Encoding examples: 0→1000000, 1→1111001, 8→0000000, A→0001000, b→0000011, F→0001110.

EN=0:
- Counters are held, AN all ones, SEG=7'h7F.
- Re-enabling resumes from the held index.

SYNC:
- Writing CTRL with bit1=1 zeros the prescaler, index, frame count and blink phase on that edge.
- The other CTRL fields in the same write take effect on the same edge.

Simultaneous events:
- A DATA write on the edge the index advances is visible on the output one cycle later (normal registered latency); no tearing within a digit slot.

Optional Feature:
HEX_PWM_EN:
- Enabled: CTRL bits[31:28] BRIGHT (reset 4'hF). A free-running 4-bit duty counter increments every clock. While the counter > BRIGHT, AN is forced to all ones (SEG unchanged). BRIGHT=F means always on; BRIGHT=0 means 1/16 duty.
- Disabled: CTRL[31:28] reads 0, writes are ignored, digits are at full duty.

Decomposition:
- Package hex_pkg: register index constants, CTRL/STATUS bit positions, SEG_BLANK=7'h7F, and the 16-entry seven-segment encoding.
- One sub-module, hex_seg7: combinational 4-bit → 7-bit active-low decoder, instantiated once on the muxed nibble.

Test Plan (bench uses SCAN_DIV=4, BLINK_FRAMES=2, DIGITS=6):
1. RST high 2 cycles, then read BASE and BASE+4 → 0x0 and 0x1. Outputs during reset: SEG=7F, AN=3F. First post-reset output: AN=3E, SEG=1000000.
2. Write DATA=0x00A1F8, observe 6 slots → AN sequence 3E,3D,3B,37,2F,1F with SEG 0000000,0001110,1111001,0001000,1000000,1000000. Then wrap to AN=3E after 24 clocks.
3. Write CTRL=0x00020001 (blink digit 1) → digit-1 slot shows SEG=7F/AN=3F for frames 2-3, normal for frames 0-1 and 4-5. STATUS bit8 toggles every 48 clocks.
4. Write CTRL=0x00000401 (blank digit 2) then CTRL=0x0 → digit 2 always dark. After the second write AN stays 3F, STATUS index is frozen, and DBUS is Z with WE=1 or when ABUS=BASE+16.
5. Mid-scan at index 4, write CTRL=0x3 → next output is AN=3E. STATUS reads index 0, phase 0. RST asserted at the same time as a DATA write → DATA reads 0.
6. With HEX_PWM_EN defined, CTRL=0x40000001 → AN low for 5 of every 16 clocks within a slot. Undefined: read CTRL → 0x00000001.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared definitions for the memory-mapped seven-segment scanner: register
// indices, CTRL/STATUS bit positions and the active-low segment encoding.
package hex_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_STATUS = 2'd2,
        REG_RSVD   = 2'd3
    } reg_idx_t;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_SYNC   = 1;
    localparam int CTRL_BLANK  = 8;
    localparam int CTRL_BLINK  = 16;
    localparam int CTRL_BRIGHT = 28;

    localparam int STAT_IDX    = 0;
    localparam int STAT_PHASE  = 8;
    localparam int STAT_EN     = 9;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // gfedcba, active-low
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg7_encode(input logic [3:0] value);
        return SEG_LUT[value];
    endfunction

endpackage

// File: rtl/hex_seg7.sv
// Combinational hex nibble to active-low seven-segment (gfedcba) decoder.
module hex_seg7
    import hex_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = seg7_encode(nibble);

endmodule

// File: rtl/mmio_hex_scan.sv
// Memory-mapped multiplexed seven-segment display controller with blank/blink masks.
// Optional macro HEX_PWM_EN adds a CTRL[31:28] brightness field driving AN duty.
module mmio_hex_scan
    import hex_pkg::*;
#(
    parameter int              BITS         = 32,
    parameter logic [BITS-1:0] BASE         = 32'hFFFFF000,
    parameter int              DIGITS       = 6,
    parameter int              SCAN_DIV     = 50000,
    parameter int              BLINK_FRAMES = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [BITS-1:0]   ABUS,
    inout  wire  [BITS-1:0]   DBUS,
    input  logic              WE,
    output logic [6:0]        SEG,
    output logic [DIGITS-1:0] AN
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(DIGITS - 1);

    // Bus: a write lands on the clock edge where sel && WE; a read is a purely
    // combinational drive of DBUS while sel && !WE, high-Z at all other times.
    logic            sel;
    logic            wr;
    logic            sync_wr;
    reg_idx_t        reg_idx;
    logic [BITS-1:0] rdata;
    logic            unused_bus;

    assign sel = ({1'b0, ABUS} >= {1'b0, BASE}) &&
                 ({1'b0, ABUS} <  ({1'b0, BASE} + (BITS+1)'(16)));
    assign wr       = sel && WE;
    assign reg_idx  = reg_idx_t'(ABUS[3:2]);
    assign sync_wr  = wr && (reg_idx == REG_CTRL) && DBUS[CTRL_SYNC];
    assign unused_bus = ^DBUS;

    logic [4*DIGITS-1:0] data_q;
    logic                en_q;
    logic [DIGITS-1:0]   blank_q;
    logic [DIGITS-1:0]   blink_q;

    logic [PW-1:0] presc_q;
    logic [2:0]    idx_q;
    logic [FW-1:0] frame_q;
    logic          phase_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q  <= '0;
            en_q    <= 1'b1;
            blank_q <= '0;
            blink_q <= '0;
        end else if (wr) begin
            case (reg_idx)
                REG_DATA: data_q <= DBUS[4*DIGITS-1:0];
                REG_CTRL: begin
                    en_q    <= DBUS[CTRL_EN];
                    blank_q <= DBUS[CTRL_BLANK +: DIGITS];
                    blink_q <= DBUS[CTRL_BLINK +: DIGITS];
                end
                default: ;
            endcase
        end
    end

    // Counting uses the EN value from before a CTRL write on the same edge.
    always_ff @(posedge CLK) begin
        if (RST || sync_wr) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
        end else if (en_q) begin
            if (presc_q == PRESC_LAST) begin
                presc_q <= '0;
                if (idx_q == IDX_LAST) begin
                    idx_q <= '0;
                    if (frame_q == FRAME_LAST) begin
                        frame_q <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        frame_q <= frame_q + 1'b1;
                    end
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    logic pwm_off;
`ifdef HEX_PWM_EN
    logic [3:0] bright_q;
    logic [3:0] duty_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            bright_q <= 4'hF;
            duty_q   <= '0;
        end else begin
            duty_q <= duty_q + 1'b1;
            if (wr && (reg_idx == REG_CTRL)) begin
                bright_q <= DBUS[CTRL_BRIGHT +: 4];
            end
        end
    end

    assign pwm_off = (duty_q > bright_q);
`else
    assign pwm_off = 1'b0;
`endif

    logic [3:0]        nibble;
    logic [DIGITS-1:0] an_onehot;
    logic              digit_dark;
    logic              dark;
    logic [6:0]        seg_dec;

    always_comb begin
        nibble     = '0;
        an_onehot  = '1;
        digit_dark = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                nibble       = data_q[4*i +: 4];
                an_onehot[i] = 1'b0;
                digit_dark   = blank_q[i] | (blink_q[i] & phase_q);
            end
        end
        dark = !en_q || digit_dark;
    end

    hex_seg7 u_seg7 (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            SEG <= SEG_BLANK;
            AN  <= '1;
        end else begin
            SEG <= dark ? SEG_BLANK : seg_dec;
            AN  <= (dark || pwm_off) ? '1 : an_onehot;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_DATA: rdata[4*DIGITS-1:0] = data_q;
            REG_CTRL: begin
                rdata[CTRL_EN]                = en_q;
                rdata[CTRL_BLANK +: DIGITS]   = blank_q;
                rdata[CTRL_BLINK +: DIGITS]   = blink_q;
`ifdef HEX_PWM_EN
                rdata[CTRL_BRIGHT +: 4]       = bright_q;
`endif
            end
            REG_STATUS: begin
                rdata[STAT_IDX +: 3]  = idx_q;
                rdata[STAT_PHASE]     = phase_q;
                rdata[STAT_EN]        = en_q;
            end
            default: ;
        endcase
    end

    assign DBUS = (sel && !WE) ? rdata : {BITS{1'bz}};

endmodule
